// File: rtl/proc_scheduler.sv
// ============================================================================
// Module      : proc_scheduler
// Description : Round-robin process scheduler with fixed instruction quantum
//               and req/ack PC hand-off. Optional macro: SCHED_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module proc_scheduler #(
  parameter int NUM_PROC = 4,
  parameter int PID_W    = 2,
  parameter int QUANTUM  = 16
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             i_halt,
  input  logic             i_load_valid,
  input  logic [PID_W-1:0] i_load_id,
  input  logic [31:0]      i_load_pc,
  input  logic             i_start,
  input  logic             i_instr_tick,
  input  logic             i_end_proc,
  input  logic [31:0]      i_pc_curr,
  input  logic             i_sw_ack,
  output logic             o_sw_req,
  output logic [31:0]      o_pc_restore,
  output logic [PID_W-1:0] o_cur_pid,
  output logic             o_exec_process,
  output logic             o_all_done,
  output logic [15:0]      o_ctx_switches
);

  localparam int QW = $clog2(QUANTUM);
  localparam logic [QW-1:0] C_Q_LAST = QW'(QUANTUM - 1);

  typedef enum logic [2:0] {
    S_OS       = 3'd0,
    S_PICK     = 3'd1,
    S_DISPATCH = 3'd2,
    S_RUN      = 3'd3,
    S_SAVE     = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [NUM_PROC-1:0] r_ready;
  logic [31:0]         r_pc [NUM_PROC];
  logic [PID_W-1:0]    r_cur_pid;
  logic                r_fresh;
  logic [QW-1:0]       r_qcnt;
  logic                r_sw_req;
  logic                r_exec;
  logic                r_all_done;

  logic                w_tick;
  logic                w_ack;
  logic                w_pick_found;
  logic [PID_W-1:0]    w_pick_id;
  logic [PID_W-1:0]    w_scan_base;

  assign w_tick = i_instr_tick && !i_halt;
  assign w_ack  = (r_state == S_DISPATCH) && r_sw_req && i_sw_ack;

  // Scan downward in offset so the nearest ready slot after the base wins.
  always_comb begin
    logic [PID_W-1:0] v_idx;
    w_pick_found = 1'b0;
    w_pick_id    = '0;
    v_idx        = '0;
    w_scan_base  = r_fresh ? '0 : r_cur_pid + 1'b1;
    for (int i = NUM_PROC - 1; i >= 0; i--) begin
      v_idx = w_scan_base + PID_W'(i);
      if (r_ready[v_idx]) begin
        w_pick_found = 1'b1;
        w_pick_id    = v_idx;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_OS:       if (i_start) w_next = S_PICK;
      S_PICK:     w_next = w_pick_found ? S_DISPATCH : S_OS;
      S_DISPATCH: if (w_ack) w_next = S_RUN;
      S_RUN: begin
        if (i_end_proc)                         w_next = S_PICK;
        else if (w_tick && r_qcnt == C_Q_LAST)  w_next = S_SAVE;
      end
      S_SAVE:     w_next = S_PICK;
      default:    w_next = S_OS;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state    <= S_OS;
      r_ready    <= '0;
      for (int i = 0; i < NUM_PROC; i++) r_pc[i] <= 32'h0;
      r_cur_pid  <= '0;
      r_fresh    <= 1'b1;
      r_qcnt     <= '0;
      r_sw_req   <= 1'b0;
      r_exec     <= 1'b0;
      r_all_done <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_sw_req   <= (w_next == S_DISPATCH);
      r_exec     <= (w_next == S_RUN);
      r_all_done <= (r_state == S_PICK) && !w_pick_found;
      case (r_state)
        S_OS: begin
          if (i_load_valid) begin
            r_ready[i_load_id] <= 1'b1;
            r_pc[i_load_id]    <= i_load_pc;
          end
        end
        S_PICK: begin
          // An empty scan restarts the next round from slot 0.
          r_cur_pid <= w_pick_found ? w_pick_id : '0;
          r_fresh   <= !w_pick_found;
        end
        S_DISPATCH: if (w_ack) r_qcnt <= '0;
        S_RUN: begin
          if (i_end_proc)  r_ready[r_cur_pid] <= 1'b0;
          else if (w_tick) r_qcnt <= r_qcnt + 1'b1;
        end
        S_SAVE:  r_pc[r_cur_pid] <= i_pc_curr;
        default: ;
      endcase
    end
  end

`ifdef SCHED_STATS_EN
  logic [15:0] r_ctx;
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)   r_ctx <= 16'h0000;
    else if (w_ack) r_ctx <= r_ctx + 16'd1;
  end
  assign o_ctx_switches = r_ctx;
`else
  assign o_ctx_switches = 16'h0000;
`endif

  assign o_sw_req       = r_sw_req;
  assign o_pc_restore   = r_sw_req ? r_pc[r_cur_pid] : 32'h0;
  assign o_cur_pid      = r_cur_pid;
  assign o_exec_process = r_exec;
  assign o_all_done     = r_all_done;

endmodule

`default_nettype wire

// File: tb/tb_proc_scheduler.sv
// ============================================================================
// Module      : tb_proc_scheduler
// Description : Self-checking bench for proc_scheduler against a slot-table model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_proc_scheduler;

  localparam int N  = 4;
  localparam int PW = 2;
  localparam int Q  = 16;

  logic          clk = 1'b0;
  logic          n_reset = 1'b0;
  logic          i_halt = 1'b0;
  logic          i_load_valid = 1'b0;
  logic [PW-1:0] i_load_id = '0;
  logic [31:0]   i_load_pc = 32'h0;
  logic          i_start = 1'b0;
  logic          i_instr_tick = 1'b0;
  logic          i_end_proc = 1'b0;
  logic [31:0]   i_pc_curr = 32'h0;
  logic          i_sw_ack = 1'b0;
  logic          o_sw_req;
  logic [31:0]   o_pc_restore;
  logic [PW-1:0] o_cur_pid;
  logic          o_exec_process;
  logic          o_all_done;
  logic [15:0]   o_ctx_switches;

  int n_chk  = 0;
  int n_fail = 0;

  bit          m_ready [N];
  logic [31:0] m_pc    [N];
  int          m_cur;
  bit          m_fresh;
  int          m_ctx;

  proc_scheduler #(.NUM_PROC(N), .PID_W(PW), .QUANTUM(Q)) dut (
    .clk(clk), .n_reset(n_reset), .i_halt(i_halt), .i_load_valid(i_load_valid),
    .i_load_id(i_load_id), .i_load_pc(i_load_pc), .i_start(i_start),
    .i_instr_tick(i_instr_tick), .i_end_proc(i_end_proc), .i_pc_curr(i_pc_curr),
    .i_sw_ack(i_sw_ack), .o_sw_req(o_sw_req), .o_pc_restore(o_pc_restore),
    .o_cur_pid(o_cur_pid), .o_exec_process(o_exec_process), .o_all_done(o_all_done),
    .o_ctx_switches(o_ctx_switches)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int model_pick();
    int base = m_fresh ? 0 : (m_cur + 1) % N;
    for (int i = 0; i < N; i++)
      if (m_ready[(base + i) % N]) return (base + i) % N;
    return -1;
  endfunction

  function automatic logic [15:0] exp_ctx();
`ifdef SCHED_STATS_EN
    return 16'(m_ctx);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_ready[i] = 1'b0;
      m_pc[i]    = 32'h0;
    end
    m_cur = 0; m_fresh = 1'b1; m_ctx = 0;
  endtask

  task automatic do_reset();
    i_halt = 0; i_load_valid = 0; i_start = 0; i_instr_tick = 0;
    i_end_proc = 0; i_sw_ack = 0; i_pc_curr = 0;
    n_reset = 1'b0;
    step(); step();
    n_reset = 1'b1;
    model_reset();
  endtask

  task automatic load(input int id, input logic [31:0] pc);
    i_load_valid = 1'b1; i_load_id = PW'(id); i_load_pc = pc;
    step();
    i_load_valid = 1'b0;
    m_ready[id] = 1'b1; m_pc[id] = pc;
  endtask

  task automatic do_start();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic expect_dispatch(output bit got);
    int p = model_pick();
    int w = 0;
    got = 1'b0;
    while (w < 6 && !(o_sw_req || o_all_done)) begin
      step();
      w++;
    end
    n_chk++;
    if (!(o_sw_req || o_all_done)) begin
      n_fail++;
      $display("FAIL pick_timeout: got sw_req=%0b all_done=%0b expected one of them high", o_sw_req, o_all_done);
      return;
    end
    if (p < 0) begin
      n_chk++;
      if (o_all_done !== 1'b1 || o_sw_req !== 1'b0 || o_exec_process !== 1'b0 || o_cur_pid !== '0) begin
        n_fail++;
        $display("FAIL all_done_pulse: got all_done=%0b sw_req=%0b exec=%0b pid=%0d expected 1 0 0 0",
                 o_all_done, o_sw_req, o_exec_process, o_cur_pid);
      end
      step();
      n_chk++;
      if (o_all_done !== 1'b0) begin
        n_fail++;
        $display("FAIL all_done_width: got %0b expected 0", o_all_done);
      end
      m_cur = 0; m_fresh = 1'b1;
    end else begin
      got = 1'b1;
      n_chk++;
      if (o_sw_req !== 1'b1 || o_cur_pid !== PW'(p) || o_pc_restore !== m_pc[p] || o_exec_process !== 1'b0) begin
        n_fail++;
        $display("FAIL dispatch: got req=%0b pid=%0d pc=%0h exec=%0b expected 1 %0d %0h 0",
                 o_sw_req, o_cur_pid, o_pc_restore, o_exec_process, p, m_pc[p]);
      end
      m_cur = p; m_fresh = 1'b0;
    end
  endtask

  task automatic ack(input int hold);
    for (int c = 0; c < hold; c++) begin
      i_sw_ack = 1'b0;
      step();
      n_chk++;
      if (o_sw_req !== 1'b1 || o_pc_restore !== m_pc[m_cur] || o_exec_process !== 1'b0) begin
        n_fail++;
        $display("FAIL ack_hold: got req=%0b pc=%0h exec=%0b expected 1 %0h 0",
                 o_sw_req, o_pc_restore, o_exec_process, m_pc[m_cur]);
      end
    end
    i_sw_ack = 1'b1;
    step();
    i_sw_ack = 1'b0;
    m_ctx++;
    n_chk++;
    if (o_exec_process !== 1'b1 || o_sw_req !== 1'b0 || o_ctx_switches !== exp_ctx()) begin
      n_fail++;
      $display("FAIL ack_edge: got exec=%0b req=%0b ctx=%0h expected 1 0 %0h",
               o_exec_process, o_sw_req, o_ctx_switches, exp_ctx());
    end
  endtask

  // end_at < 0: run to quantum expiry; otherwise end_proc once end_at ticks have counted.
  task automatic run_slice(input logic [31:0] pcv, input int end_at, input bit use_halt, input bit force_tick);
    int cnt = 0;
    bit fin = 1'b0;
    bit ended, eff;
    for (int c = 0; c < 400 && !fin; c++) begin
      i_instr_tick = force_tick ? 1'b1 : ($urandom_range(0, 3) != 0);
      i_halt       = use_halt ? ($urandom_range(0, 3) == 0) : 1'b0;
      i_end_proc   = (end_at >= 0 && cnt == end_at);
      i_pc_curr    = pcv;
      ended = i_end_proc;
      eff   = i_instr_tick && !i_halt;
      step();
      i_end_proc = 1'b0; i_instr_tick = 1'b0; i_halt = 1'b0;
      if (ended) begin
        fin = 1'b1;
        m_ready[m_cur] = 1'b0;
        n_chk++;
        if (o_exec_process !== 1'b0) begin
          n_fail++;
          $display("FAIL end_exec: got %0b expected 0", o_exec_process);
        end
      end else begin
        if (eff) cnt++;
        n_chk++;
        if (cnt == Q) begin
          fin = 1'b1;
          m_pc[m_cur] = pcv;
          if (o_exec_process !== 1'b0) begin
            n_fail++;
            $display("FAIL expire_exec: got %0b expected 0 after tick %0d", o_exec_process, cnt);
          end
        end else if (o_exec_process !== 1'b1) begin
          n_fail++;
          $display("FAIL run_exec: got %0b expected 1 at tick count %0d", o_exec_process, cnt);
        end
      end
    end
    n_chk++;
    if (!fin) begin
      n_fail++;
      $display("FAIL slice_timeout: got unfinished slice expected finish");
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if (o_sw_req !== 1'b0 || o_pc_restore !== 32'h0 || o_cur_pid !== '0 ||
        o_exec_process !== 1'b0 || o_all_done !== 1'b0 || o_ctx_switches !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state: got req=%0b pc=%0h pid=%0d exec=%0b done=%0b ctx=%0h expected all 0",
               o_sw_req, o_pc_restore, o_cur_pid, o_exec_process, o_all_done, o_ctx_switches);
    end
  endtask

  task automatic test_basic();
    bit got;
    do_reset();
    load(0, 32'h40);
    load(2, 32'h80);
    do_start();
    expect_dispatch(got);
    ack(0);
    // A registration attempt while running must not create slot 3.
    i_load_valid = 1'b1; i_load_id = 2'd3; i_load_pc = 32'hDEAD;
    step();
    i_load_valid = 1'b0;
    n_chk++;
    if (o_exec_process !== 1'b1) begin
      n_fail++;
      $display("FAIL load_in_run: got exec=%0b expected 1", o_exec_process);
    end
    run_slice(32'h50, -1, 1'b0, 1'b0);
    expect_dispatch(got);
    ack(0);
    run_slice(32'h99, Q - 1, 1'b0, 1'b1);
    expect_dispatch(got);
    ack(0);
    run_slice(32'h0, int'($urandom_range(0, Q - 1)), 1'b0, 1'b0);
    expect_dispatch(got);
  endtask

  task automatic test_single_and_halt();
    bit got;
    do_reset();
    load(1, 32'h10);
    do_start();
    expect_dispatch(got);
    ack(5);
    run_slice(32'h24, -1, 1'b0, 1'b0);
    expect_dispatch(got);
    ack(0);
    i_pc_curr = 32'h300;
    for (int i = 0; i < 25; i++) begin
      i_instr_tick = 1'b1;
      i_halt = (i >= 5 && i < 15);
      step();
      n_chk++;
      if (o_exec_process !== 1'b1) begin
        n_fail++;
        $display("FAIL halt_frozen: got exec=%0b expected 1 at cycle %0d", o_exec_process, i);
      end
    end
    i_halt = 1'b0;
    step();
    i_instr_tick = 1'b0;
    m_pc[m_cur] = 32'h300;
    n_chk++;
    if (o_exec_process !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_expire: got exec=%0b expected 0", o_exec_process);
    end
    expect_dispatch(got);
    ack(0);
    run_slice(32'h0, 3, 1'b1, 1'b0);
    expect_dispatch(got);
  endtask

  task automatic test_random();
    bit got;
    int slices = 0;
    bit any = 1'b0;
    do_reset();
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 1) == 1 || (i == N - 1 && !any)) begin
        load(i, $urandom & 32'hFFFF_FFFC);
        any = 1'b1;
      end
    end
    do_start();
    got = 1'b1;
    while (got && slices < 60) begin
      expect_dispatch(got);
      if (got) begin
        ack(int'($urandom_range(0, 3)));
        if ($urandom_range(0, 1) == 1)
          run_slice($urandom, int'($urandom_range(0, Q - 1)), 1'b1, 1'b0);
        else
          run_slice($urandom, -1, 1'b1, 1'b0);
      end
      slices++;
    end
    n_chk++;
    if (got) begin
      n_fail++;
      $display("FAIL random_finish: got still dispatching expected all_done within 60 slices");
    end
  endtask

  task automatic test_reset_dispatch();
    bit got;
    do_reset();
    load(3, 32'hABC);
    do_start();
    expect_dispatch(got);
    #2 n_reset = 1'b0;
    #1;
    n_chk++;
    if (o_sw_req !== 1'b0 || o_pc_restore !== 32'h0 || o_cur_pid !== '0 ||
        o_exec_process !== 1'b0 || o_all_done !== 1'b0 || o_ctx_switches !== 16'h0) begin
      n_fail++;
      $display("FAIL async_reset: got req=%0b pc=%0h pid=%0d exec=%0b done=%0b ctx=%0h expected all 0",
               o_sw_req, o_pc_restore, o_cur_pid, o_exec_process, o_all_done, o_ctx_switches);
    end
    step();
    n_reset = 1'b1;
    model_reset();
    i_sw_ack = 1'b1;
    step();
    i_sw_ack = 1'b0;
    n_chk++;
    if (o_sw_req !== 1'b0 || o_exec_process !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got req=%0b exec=%0b expected 0 0", o_sw_req, o_exec_process);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_single_and_halt();
    for (int r = 0; r < 4; r++) test_random();
    test_reset_dispatch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/proc_scheduler.md
Name: proc_scheduler

Overview:
- Round-robin process scheduler sitting directly upstream of the core's process-switch logic.
- Holds a small process table of ready/done flags and saved PCs.
- Preempts the running process after a fixed instruction quantum and hands the next PC to the program counter path through a req/ack handshake.
- Produces the exec_process flag and the current process id consumed by the control unit and the register bank.

Parameters:
NUM_PROC, 4, number of process slots (power of two, 2..16)
PID_W, 2, process id width, log2(NUM_PROC)
QUANTUM, 16, retired instructions per time slice (>=2)

Ports:
clk  in  1  system clock (divided core clock)
n_reset  in  1  asynchronous active-low reset
halt  in  1  core halted; freezes quantum counting
load_valid  in  1  OS registers a process this cycle
load_id  in  PID_W  slot to register
load_pc  in  32  entry PC of that process
start  in  1  one-cycle pulse: OS hands control to scheduler
instr_tick  in  1  one pulse per retired instruction
end_proc  in  1  one-cycle pulse: current process finished
pc_curr  in  32  current program counter (saved on preemption)
sw_ack  in  1  PC path accepted pc_restore
sw_req  out  1  pc_restore valid, held until acknowledged
pc_restore  out  32  PC to load for the dispatched process
cur_pid  out  PID_W  id of the running/dispatched process
exec_process  out  1  high while a user process runs
all_done  out  1  one-cycle pulse: no ready process remains
ctx_switches  out  16  completed dispatch count

Behaviour:
- Reset is asynchronous on n_reset low: state OS, all slots free, all saved PCs 0, all outputs 0.
- States: OS, PICK, DISPATCH, RUN, SAVE.
- OS:
  - exec_process=0.
  - load_valid marks slot load_id ready and stores load_pc. load_valid is ignored in every other state.
  - start moves to PICK. The scan pointer starts at slot 0 after reset or all_done.
- PICK (1 cycle):
  - Single-cycle combinational scan from (cur_pid+1) mod NUM_PROC, wrapping. The current slot is included last.
  - First ready slot found: cur_pid updated, go to DISPATCH.
  - None found: all_done=1 for this cycle, go to OS, cur_pid=0.
- DISPATCH:
  - sw_req=1 and pc_restore=saved PC of cur_pid.
  - Both are held stable until a rising edge with sw_req&&sw_ack. That edge goes to RUN, clears the quantum counter, and increments ctx_switches (wraps at 0xFFFF).
  - sw_ack outside DISPATCH is ignored.
- RUN:
  - exec_process=1.
  - instr_tick&&!halt increments the quantum counter.
  - A tick while counter==QUANTUM-1 goes to SAVE. Preemption latency is 1 cycle after the qualifying tick.
  - end_proc marks cur_pid done (not ready) and goes straight to PICK without saving.
  - If end_proc and the expiring tick arrive in the same cycle, end_proc wins.
- SAVE (1 cycle): saved PC of cur_pid <= pc_curr; slot stays ready; go to PICK.
- If a single ready process is preempted, it is re-picked and re-dispatched with its saved PC.
- halt held high in RUN: counter frozen, state held; end_proc is still honoured.
- Reset mid-DISPATCH drops sw_req immediately (asynchronous).
- exec_process, cur_pid and sw_req are registered outputs; all_done is a registered pulse.

Optional Feature:
- Macro SCHED_STATS_EN.
- Defined: ctx_switches counts completed dispatches as described.
- Undefined: the counter register is not built and ctx_switches is tied to 16'h0000. All other behaviour is identical.

Test Plan:
- Reset, load slots 0 and 2 with PCs 0x40 and 0x80, then start → sw_req with pc_restore=0x40, cur_pid=0. Ack → exec_process=1, ctx_switches=1.
- In RUN on slot 0, send 16 instr_tick with pc_curr=0x50 → SAVE stores 0x50; next dispatch is pid 2 with pc_restore=0x80.
- Only slot 1 ready (PC 0x10), QUANTUM expiry at pc_curr=0x24 → re-dispatch pid 1 with pc_restore=0x24.
- end_proc on the same cycle as the 16th tick → no save; slot marked done. With no other ready slot: all_done pulse, exec_process=0, state OS.
- Hold sw_ack low 5 cycles in DISPATCH → sw_req and pc_restore stable throughout; exec_process stays 0 until the ack edge.
- halt high for 10 ticks mid-quantum → counter frozen; preemption happens only after the remaining ticks arrive with halt low. n_reset pulse during DISPATCH → all outputs 0 asynchronously.
